// File: rtl/core_pkg.sv
// Shared core widths and types for the RV32I datapath.
// Used by the register file, ALU and decoder alike.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_file_if.sv
// Register file access bundle: two read ports, one write
// port, a debug read port and the ready indication.
interface reg_file_if;
    import core_pkg::*;

    reg_addr_t rs1_addr;
    reg_addr_t rs2_addr;
    xlen_t     rs1_data;
    xlen_t     rs2_data;
    logic      reg_write;
    reg_addr_t rd_addr;
    xlen_t     rd_data;
    logic      ready;
    reg_addr_t dbg_addr;
    xlen_t     dbg_data;

    modport master (
        output rs1_addr,
        output rs2_addr,
        output reg_write,
        output rd_addr,
        output rd_data,
        output dbg_addr,
        input  rs1_data,
        input  rs2_data,
        input  ready,
        input  dbg_data
    );

    modport slave (
        input  rs1_addr,
        input  rs2_addr,
        input  reg_write,
        input  rd_addr,
        input  rd_data,
        input  dbg_addr,
        output rs1_data,
        output rs2_data,
        output ready,
        output dbg_data
    );

endinterface

// File: rtl/reg_file_init.sv
// Post-reset clear sequencer: sweeps x1..x(NREGS-1) one
// entry per cycle, then holds RUN and raises ready.
module reg_file_init
    import core_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    output logic      clr_en,
    output reg_addr_t clr_idx,
    output logic      ready
);

    rf_state_e state_q;
    rf_state_e state_d;
    reg_addr_t clr_idx_q;
    reg_addr_t clr_idx_d;

    localparam reg_addr_t LAST_IDX = reg_addr_t'(NREGS - 1);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == RF_CLEAR) begin
            if (clr_idx_q == LAST_IDX) begin
                state_d = RF_RUN;
            end else begin
                clr_idx_d = clr_idx_q + reg_addr_t'(1);
            end
        end
    end

    // x0 is never stored, so the sweep starts at x1
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= reg_addr_t'(1);
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign clr_en  = (state_q == RF_CLEAR);
    assign clr_idx = clr_idx_q;
    assign ready   = (state_q == RF_RUN);

endmodule

// File: rtl/reg_file.sv
// RV32I integer register file: 2 async reads, 1 sync write,
// unreset storage zeroed by reg_file_init after reset.
module reg_file
    import core_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  rf
);

    xlen_t     mem_q [NREGS];
    logic      clr_en;
    reg_addr_t clr_idx;
    logic      run;
    logic      wr_en;
    reg_addr_t wr_addr;
    xlen_t     wr_data;

    reg_file_init u_init (
        .clk     (clk),
        .rst     (rst),
        .clr_en  (clr_en),
        .clr_idx (clr_idx),
        .ready   (run)
    );

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_idx;
        wr_data = '0;
        if (!rst) begin
            if (clr_en) begin
                wr_en = 1'b1;
            end else if (rf.reg_write &&
                         rf.rd_addr != '0) begin
                wr_en   = 1'b1;
                wr_addr = rf.rd_addr;
                wr_data = rf.rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // No write bypass: rd_data depends on these via the ALU
    function automatic xlen_t rd_port(input reg_addr_t a);
        if (!run || a == '0) begin
            return '0;
        end
        return mem_q[a];
    endfunction

    assign rf.rs1_data = rd_port(rf.rs1_addr);
    assign rf.rs2_data = rd_port(rf.rs2_addr);
    assign rf.dbg_data = rd_port(rf.dbg_addr);
    assign rf.ready    = run;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;
    import core_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    reg_file_if rf_if ();

    reg_file dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h want %08h",
                     tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!rf_if.ready && n < 100) begin
            tick();
            n++;
        end
        rf_if.reg_write = 1'b0;
    endtask

    task automatic wr(input reg_addr_t a,
                      input xlen_t d);
        rf_if.reg_write = 1'b1;
        rf_if.rd_addr   = a;
        rf_if.rd_data   = d;
        tick();
        rf_if.reg_write = 1'b0;
    endtask

    int  n;
    logic all_zero;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        rf_if.rs1_addr  = '0;
        rf_if.rs2_addr  = '0;
        rf_if.reg_write = 1'b0;
        rf_if.rd_addr   = '0;
        rf_if.rd_data   = '0;
        rf_if.dbg_addr  = '0;

        // 1: reset and init
        repeat (3) tick();
        check("rst_ready", {31'd0, rf_if.ready}, 32'd0);
        rst = 1'b0;
        wait_ready(n);
        check("init_edges", n, 32'd31);
        check("init_ready", {31'd0, rf_if.ready}, 32'd1);
        all_zero = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            rf_if.dbg_addr = reg_addr_t'(i);
            #1;
            if (rf_if.dbg_data !== '0) all_zero = 1'b0;
        end
        check("init_all_zero", {31'd0, all_zero}, 32'd1);

        // 2: basic write/read, old value in write cycle
        rf_if.rs1_addr  = 5;
        rf_if.rs2_addr  = 5;
        rf_if.reg_write = 1'b1;
        rf_if.rd_addr   = 5;
        rf_if.rd_data   = 32'hDEADBEEF;
        #1;
        check("rdw_old", rf_if.rs1_data, 32'h0);
        tick();
        rf_if.reg_write = 1'b0;
        check("rs1_x5", rf_if.rs1_data, 32'hDEADBEEF);
        check("rs2_x5", rf_if.rs2_data, 32'hDEADBEEF);
        wr(6, 32'h0BADF00D);
        rf_if.rs2_addr = 6;
        rf_if.dbg_addr = 5;
        #1;
        check("rs1_x5b", rf_if.rs1_data, 32'hDEADBEEF);
        check("rs2_x6", rf_if.rs2_data, 32'h0BADF00D);
        check("dbg_x5", rf_if.dbg_data, 32'hDEADBEEF);
        wr(5, 32'h00000001);
        check("rs1_x5_ovr", rf_if.rs1_data, 32'h1);

        // 3: x0 protection
        wr(0, 32'hFFFFFFFF);
        rf_if.rs1_addr = 0;
        rf_if.dbg_addr = 0;
        #1;
        check("x0_rs1", rf_if.rs1_data, 32'h0);
        check("x0_dbg", rf_if.dbg_data, 32'h0);

        // 4: writes blocked during CLEAR
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rf_if.reg_write = 1'b1;
        rf_if.rd_addr   = 7;
        rf_if.rd_data   = 32'h12345678;
        wait_ready(n);
        check("blk_edges", n, 32'd31);
        rf_if.dbg_addr = 7;
        #1;
        check("blk_x7", rf_if.dbg_data, 32'h0);
        rf_if.dbg_addr = 6;
        #1;
        check("blk_x6", rf_if.dbg_data, 32'h0);

        // 5: reset mid-init
        wr(20, 32'hA5A5A5A5);
        rf_if.dbg_addr = 20;
        #1;
        check("pre_x20", rf_if.dbg_data, 32'hA5A5A5A5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_ready0", {31'd0, rf_if.ready}, 32'd0);
        check("clr_gate", rf_if.dbg_data, 32'h0);
        repeat (10) tick();
        check("mid_ready10", {31'd0, rf_if.ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ready(n);
        check("mid_edges", n, 32'd31);
        check("mid_x20", rf_if.dbg_data, 32'h0);

        // 6: reset vs write collision
        rst = 1'b1;
        rf_if.reg_write = 1'b1;
        rf_if.rd_addr   = 3;
        rf_if.rd_data   = 32'h1;
        tick();
        rst = 1'b0;
        rf_if.reg_write = 1'b0;
        check("col_ready", {31'd0, rf_if.ready}, 32'd0);
        wait_ready(n);
        check("col_edges", n, 32'd31);
        rf_if.rs1_addr = 3;
        #1;
        check("col_x3", rf_if.rs1_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
Integer register file (x0..x31) for the single-cycle RV32I core, sitting directly upstream of the ALU.
- Two asynchronous read ports drive the ALU's rs1_data/rs2_data operands.
- One synchronous write port takes the write-back value (ALU result, load data or link address).
- Storage is a memory array with no per-entry reset, so it maps to FPGA distributed RAM. After reset, an init sequencer zeroes the array one entry per cycle and signals ready when finished.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two; x0 included)
AW, $clog2(NREGS), register address width

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
rs1_addr  in  AW  read port 1 address
rs2_addr  in  AW  read port 2 address
rs1_data  out  XLEN  read port 1 data (combinational)
rs2_data  out  XLEN  read port 2 data (combinational)
reg_write  in  1  write enable
rd_addr  in  AW  write address
rd_data  in  XLEN  write data
ready  out  1  1 = init complete, file usable; core must stall while 0
dbg_addr  in  AW  debug/testbench read address
dbg_data  out  XLEN  debug read data (combinational)

Behaviour:
- State machine has two states: CLEAR and RUN. An init counter clr_idx (AW bits) selects the entry being cleared.
- rst=1 at an edge: state<=CLEAR, clr_idx<=1, from any state, including mid-CLEAR (restarts the sweep from x1). Array contents are not touched by reset itself.
- CLEAR behaviour, each edge with rst=0:
  - mem[clr_idx]<=0.
  - If clr_idx==NREGS-1, state<=RUN; otherwise clr_idx<=clr_idx+1.
  - x1..x31 are cleared over NREGS-1 = 31 edges. ready goes high after the 31st edge with rst low.
- ready = (state==RUN). It is 0 during reset and throughout CLEAR, and is registered (glitch-free).
- Reads in CLEAR: rs1_data, rs2_data and dbg_data are forced to 0.
- Writes in CLEAR: ignored, regardless of reg_write.
- Reads in RUN:
  - rsN_data = 0 if rsN_addr==0, else mem[rsN_addr]; purely combinational, zero-cycle latency.
  - dbg_data follows the same rule.
- Writes in RUN: at an edge with reg_write=1 and rd_addr!=0, mem[rd_addr]<=rd_data. Writes to x0 are discarded.
- Read-during-write to the same address in the same cycle returns the OLD value; the new value is visible after the edge.
- No write-to-read bypass. This is mandatory: rd_data derives combinationally from rs data through the ALU in the single-cycle datapath, so a bypass would create a combinational loop.
- x0 is never stored as a read source. x0 reads are 0 by address decode, so the array entry mem[0] is don't-care.
- Simultaneous rst and reg_write: rst wins; no write occurs.
- Outputs during/after reset:
  - ready=0 from the first rst edge.
  - Data outputs read 0 until RUN.
- X-safety: an uninitialised array before the first reset must not propagate, because the outputs are gated to 0 while not in RUN. After power-up, state is undefined until the first rst pulse; the core's reset guarantees that pulse.

Decomposition:
- Shared package core_pkg provides:
  - XLEN and REG_AW constants;
  - typedef reg_addr_t (logic [REG_AW-1:0]);
  - typedef xlen_t (logic [XLEN-1:0]);
  - enum rf_state_e {RF_CLEAR, RF_RUN}.
  The ALU and decoder share the same widths.
- One sub-module is natural: reg_file_init, containing the state register, clr_idx counter and ready generation. It exports clr_en/clr_idx to the array write mux. The array and read muxes stay in reg_file.

Test Plan:
1. Reset and init: hold rst 3 cycles, then release. ready=0 for exactly 31 edges and =1 after the 31st. All 32 dbg_addr reads return 0x00000000 once ready=1.
2. Basic write/read: write x5=0xDEADBEEF, then set rs1_addr=5 and rs2_addr=5. Both outputs read 0xDEADBEEF in the next cycle. In the write cycle itself, rs1_data shows the old value 0.
3. x0 protection: reg_write=1, rd_addr=0, rd_data=0xFFFFFFFF. Next cycle rs1_addr=0 gives 0x00000000.
4. Writes blocked in CLEAR: after rst release, drive reg_write=1, rd_addr=7, rd_data=0x12345678 on every CLEAR cycle. After ready=1, x7 reads 0.
5. Reset mid-init: pre-load x20=0xA5A5A5A5 in RUN. Assert rst, release, then re-assert rst for 1 cycle after 10 CLEAR edges. ready rises only after 31 further edges with rst low, and x20 reads 0.
6. Reset vs write collision: in RUN, assert rst together with reg_write=1, rd_addr=3, rd_data=0x1. After init, x3 reads 0, and ready is 0 in the cycle after the collision.
